// File: rtl/wb_port_sched.sv
// wb_port_sched: register-file write-port scheduler.
// Takes one write-back command per handshake and drives RegDst, write-data
// source and RegWrite. Two-write ops (POP, CALL_SP) become back-to-back
// writes: the first writes the data register, the second writes $sp.
//
// state | meaning
// IDLE  | waiting for a command; reg_write low, muxes keep last selects
// WR1   | first (or only) write of the latched command
// WR2   | second write ($sp update) of POP / CALL_SP
module wb_port_sched #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [1:0]       cmd_src,
    input  logic             hold,
    output logic [2:0]       reg_dst,
    output logic [1:0]       wb_src,
    output logic             sp_inc,
    output logic             reg_write,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] wr_count
);

    typedef enum logic [1:0] {IDLE, WR1, WR2} state_t;

    localparam logic [2:0] OP_POP     = 3'd5;
    localparam logic [2:0] OP_CALL_SP = 3'd6;
    localparam logic [2:0] OP_RSVD    = 3'd7;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [2:0]       dst_q, dst_d;
    logic [1:0]       src_q, src_d;
    logic             sp_q, sp_d;
    logic             ill_q, ill_d;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             dual_op;
    logic             wr_active;

    // State, latched op and the registered mux selects (Moore outputs).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            dst_q   <= '0;
            src_q   <= '0;
            sp_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            sp_q    <= sp_d;
            ill_q   <= ill_d;
        end
    end

    // Next-state logic and next values of the mux selects for the state entered.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dst_d   = dst_q;
        src_d   = src_q;
        sp_d    = sp_q;
        ill_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cmd_op == OP_RSVD) begin
                        ill_d = 1'b1;
                    end else begin
                        state_d = WR1;
                        op_d    = cmd_op;
                        case (cmd_op)
                            OP_POP: begin
                                dst_d = 3'b000;
                                src_d = 2'b01;
                            end
                            OP_CALL_SP: begin
                                dst_d = 3'b010;
                                src_d = 2'b10;
                            end
                            default: begin
                                dst_d = cmd_op;
                                src_d = cmd_src;
                            end
                        endcase
                    end
                end
            end
            WR1: begin
                if (!hold) begin
                    if (dual_op) begin
                        state_d = WR2;
                        dst_d   = 3'b011;
                        src_d   = 2'b11;
                        sp_d    = (op_q == OP_POP);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            WR2: begin
                if (!hold) begin
                    state_d = IDLE;
                    sp_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Completed-write counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (reg_write) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign dual_op   = (op_q == OP_POP) || (op_q == OP_CALL_SP);
    assign wr_active = (state_q == WR1) || (state_q == WR2);
    assign accept    = cmd_valid && cmd_ready;

    // Reset is synchronous, so the state still reads WR1/WR2 during the
    // reset cycle; gating here keeps an aborted command from writing.
    assign cmd_ready = (state_q == IDLE) && !reset;
    assign reg_write = wr_active && !hold && !reset;
    assign done      = !hold && !reset &&
                       (((state_q == WR1) && !dual_op) || (state_q == WR2));
    assign reg_dst   = reset ? 3'b000 : dst_q;
    assign wb_src    = reset ? 2'b00 : src_q;
    assign sp_inc    = sp_q && !reset;
    assign illegal   = ill_q && !reset;
    assign wr_count  = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_wb_port_sched.sv
// Bench for wb_port_sched: each accepted command is expanded into a list of
// pending writes; the head of that list gives the expected outputs each cycle.
module tb_wb_port_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [1:0] cmd_src = '0;
    logic       hold = 1'b0;
    logic [2:0] reg_dst;
    logic [1:0] wb_src;
    logic       sp_inc, reg_write, done, illegal;
    logic [7:0] wr_count;

    int vectors = 0;
    int errors  = 0;

    wb_port_sched #(.CNT_W(8)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_src(cmd_src), .hold(hold), .reg_dst(reg_dst),
        .wb_src(wb_src), .sp_inc(sp_inc), .reg_write(reg_write), .done(done),
        .illegal(illegal), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] dst;
        logic [1:0] src;
        logic       sp;
        logic       last;
    } wr_t;

    wr_t q[$];
    logic [2:0] m_last_dst = '0;
    logic [1:0] m_last_src = '0;
    logic       m_ill = 1'b0;
    int         m_count = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: consumes the inputs present at each rising edge.
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_last_dst = '0;
            m_last_src = '0;
            m_ill      = 1'b0;
            m_count    = 0;
        end else begin
            m_ill = 1'b0;
            if (q.size() > 0) begin
                if (!hold) begin
                    m_count    = (m_count + 1) % 256;
                    m_last_dst = q[0].dst;
                    m_last_src = q[0].src;
                    void'(q.pop_front());
                end
            end else if (cmd_valid) begin
                case (cmd_op)
                    3'd7: m_ill = 1'b1;
                    3'd5: begin
                        q.push_back('{3'd0, 2'd1, 1'b0, 1'b0});
                        q.push_back('{3'd3, 2'd3, 1'b1, 1'b1});
                    end
                    3'd6: begin
                        q.push_back('{3'd2, 2'd2, 1'b0, 1'b0});
                        q.push_back('{3'd3, 2'd3, 1'b0, 1'b1});
                    end
                    default: q.push_back('{cmd_op, cmd_src, 1'b0, 1'b1});
                endcase
            end
        end
    end

    // Compare process: every cycle, mid-period.
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_ready", cmd_ready, 0);
            chk("rst_reg_write", reg_write, 0);
            chk("rst_reg_dst", reg_dst, 0);
            chk("rst_wb_src", wb_src, 0);
            chk("rst_sp_inc", sp_inc, 0);
            chk("rst_done", done, 0);
            chk("rst_illegal", illegal, 0);
            chk("rst_wr_count", wr_count, 0);
        end else if (q.size() > 0) begin
            chk("wr_ready", cmd_ready, 0);
            chk("wr_reg_dst", reg_dst, q[0].dst);
            chk("wr_wb_src", wb_src, q[0].src);
            chk("wr_sp_inc", sp_inc, q[0].sp);
            chk("wr_reg_write", reg_write, !hold);
            chk("wr_done", done, q[0].last && !hold);
            chk("wr_illegal", illegal, m_ill);
            chk("wr_count", wr_count, m_count);
        end else begin
            chk("idle_ready", cmd_ready, 1);
            chk("idle_reg_dst", reg_dst, m_last_dst);
            chk("idle_wb_src", wb_src, m_last_src);
            chk("idle_sp_inc", sp_inc, 0);
            chk("idle_reg_write", reg_write, 0);
            chk("idle_done", done, 0);
            chk("idle_illegal", illegal, m_ill);
            chk("idle_wr_count", wr_count, m_count);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [1:0] src);
        int n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        chk("ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src   = src;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        reset = 1'b0;

        // Single write, RD from ALU.
        send(3'd1, 2'd0);
        chk("t1_reg_dst", reg_dst, 1);
        chk("t1_wb_src", wb_src, 0);
        chk("t1_reg_write", reg_write, 1);
        chk("t1_done", done, 1);
        tick();
        chk("t1_ready", cmd_ready, 1);
        chk("t1_count", wr_count, 1);

        // POP.
        send(3'd5, 2'd2);
        chk("pop1_reg_dst", reg_dst, 0);
        chk("pop1_wb_src", wb_src, 1);
        chk("pop1_reg_write", reg_write, 1);
        chk("pop1_done", done, 0);
        tick();
        chk("pop2_reg_dst", reg_dst, 3);
        chk("pop2_wb_src", wb_src, 3);
        chk("pop2_sp_inc", sp_inc, 1);
        chk("pop2_done", done, 1);
        tick();
        chk("pop_count", wr_count, 3);

        // CALL_SP with three hold cycles in WR1.
        hold = 1'b1;
        send(3'd6, 2'd0);
        for (int i = 0; i < 3; i++) begin
            chk("call_hold_reg_write", reg_write, 0);
            chk("call_hold_reg_dst", reg_dst, 2);
            tick();
        end
        hold = 1'b0;
        #1;
        chk("call1_reg_write", reg_write, 1);
        chk("call1_wb_src", wb_src, 2);
        tick();
        chk("call2_reg_dst", reg_dst, 3);
        chk("call2_sp_inc", sp_inc, 0);
        chk("call2_done", done, 1);
        tick();
        chk("call_count", wr_count, 5);

        // Reserved op.
        send(3'd7, 2'd0);
        chk("ill_pulse", illegal, 1);
        chk("ill_ready", cmd_ready, 1);
        chk("ill_reg_write", reg_write, 0);
        tick();
        chk("ill_clear", illegal, 0);
        chk("ill_count", wr_count, 5);

        // Reset during WR2 of POP.
        send(3'd5, 2'd0);
        tick();
        reset = 1'b1;
        #1;
        chk("abort_reg_write", reg_write, 0);
        chk("abort_done", done, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("abort_count", wr_count, 0);
        chk("abort_reg_dst", reg_dst, 0);
        chk("abort_ready", cmd_ready, 1);

        // 260 single writes with cmd_valid held high through WR1.
        cmd_valid = 1'b1;
        for (int i = 0; i < 260; i++) begin
            cmd_op  = 3'(i % 5);
            cmd_src = 2'(i % 4);
            tick();
            tick();
        end
        cmd_valid = 1'b0;
        tick();
        chk("wrap_count", wr_count, 4);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/wb_port_sched.md
Name: wb_port_sched

Overview:
- Sequences the register-file write port of the multicycle datapath.
- Accepts one write-back command per handshake and drives the RegDst select (rt/rd/$ra/$sp/rs), RegWrite and the write-data source select, one write per cycle.
- Expands two-write commands (POP, CALL_SP) into back-to-back writes.
- Sits between the main control FSM and the RegDst/MemToReg muxes feeding the register bank.

Parameters:
- CNT_W, 8, width of the completed-write counter wr_count.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  write-back command present
- cmd_ready  output  1  scheduler can accept a command this cycle
- cmd_op  input  3  0=RT, 1=RD, 2=RA, 3=SP, 4=RS, 5=POP, 6=CALL_SP, 7=reserved
- cmd_src  input  2  data source for single-write ops: 0=ALU, 1=MEM, 2=PC, 3=SPADJ
- hold  input  1  pipeline stall; freezes write states
- reg_dst  output  3  RegDst mux select: 000 rt, 001 rd, 010 $ra(31), 011 $sp(29), 100 rs
- wb_src  output  2  write-data mux select, same encoding as cmd_src
- sp_inc  output  1  SPADJ direction: 1=+4, 0=-4; meaningful only when wb_src=3
- reg_write  output  1  register-file write enable
- done  output  1  one-cycle pulse on the final write of a command
- illegal  output  1  one-cycle pulse for a reserved op
- wr_count  output  CNT_W  number of reg_write cycles since reset, modulo 2^CNT_W

Behaviour:
- Clock clk; reset synchronous, active-high.
- While reset=1: state=IDLE, reg_write=0, reg_dst=000, wb_src=00, sp_inc=0, done=0, illegal=0, wr_count=0, cmd_ready=0.
- States: IDLE, WR1, WR2.
- cmd_ready = (state==IDLE) && !reset. It is not gated by hold.
- IDLE:
  - reg_write=0; reg_dst and wb_src hold their last values.
  - On cmd_valid && cmd_ready: latch cmd_op and cmd_src.
  - For op 7: stay IDLE and pulse illegal in the next cycle; no write occurs.
  - For ops 0-6: go to WR1.
- WR1 (first write):
  - Op 0-4: reg_dst = 000/001/010/011/100 respectively; wb_src = latched cmd_src.
  - Op 5 (POP): reg_dst=000, wb_src=01.
  - Op 6 (CALL_SP): reg_dst=010, wb_src=10.
  - reg_write = !hold.
  - hold=1: remain in WR1, outputs stable.
  - hold=0: ops 0-4 assert done and return to IDLE; ops 5-6 go to WR2 with no done.
- WR2 (second write):
  - reg_dst=011, wb_src=11.
  - sp_inc=1 for POP, 0 for CALL_SP.
  - reg_write = !hold; hold=1 remains in WR2.
  - hold=0 asserts done and returns to IDLE.
- All outputs in WR1/WR2 are registered state decodes (Moore). reg_write and done are additionally ANDed with !hold.
- Latency: single-write command takes 1 accept cycle + 1 write cycle. Dual-write command takes 1 + 2. Back-to-back peak throughput is 1 command per 2 or 3 cycles.
- wr_count increments in every cycle with reg_write=1; it wraps from 2^CNT_W-1 to 0.
- Reset asserted in WR1/WR2 aborts the command. No further write occurs: reg_write=0 in the reset cycle. The latched op is discarded.
- cmd_valid while cmd_ready=0 is ignored. The requester must hold cmd_valid until the handshake.
- sp_inc is 0 outside WR2.

Test Plan:
- Reset then cmd_op=1, cmd_src=0, one-cycle valid → next cycle: reg_dst=001, wb_src=00, reg_write=1, done=1; then IDLE with cmd_ready=1; wr_count=1.
- POP (op=5) → WR1: reg_dst=000, wb_src=01, reg_write=1. WR2: reg_dst=011, wb_src=11, sp_inc=1, done=1. wr_count +2.
- CALL_SP (op=6) with hold=1 for 3 cycles during WR1 → reg_write=0 and reg_dst=010 held for 3 cycles. Then 1 write cycle, then WR2 with reg_dst=011, sp_inc=0, done=1.
- op=7 accepted → illegal=1 for one cycle, reg_write never asserted, wr_count unchanged, cmd_ready=1 throughout.
- Reset asserted during WR2 of POP → reg_write=0 that cycle, done never pulses. After reset: all outputs at reset values, wr_count=0.
- 260 consecutive single-write commands with CNT_W=8 → wr_count wraps and reads 4. cmd_valid held high during WR1 is not re-accepted (exactly 260 writes).
